// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the ID-stage hazard controller: operand-mux select
// encoding, the tracked pipeline-stage record and the hard-wired zero register.
package pipe_hazard_unit_pkg;

    // Operand mux select encoding (ID-stage 4:1 muxes A and B).
    localparam logic [1:0] FWD_RF     = 2'b00;  // register file read
    localparam logic [1:0] FWD_EXE    = 2'b01;  // EX-stage ALU result
    localparam logic [1:0] FWD_MEM    = 2'b10;  // MEM-stage ALU result
    localparam logic [1:0] FWD_MEM_LD = 2'b11;  // MEM-stage load data

    // Register $0 is hard-wired to zero and never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // What the hazard unit remembers about an instruction in a later stage.
    typedef struct packed {
        logic       wreg;   // writes the register file
        logic       m2reg;  // result comes from data memory (load)
        logic [4:0] rn;     // destination register
    } stage_t;

    // Empty slot inserted on stall, flush, reset or an invalid ID instruction.
    localparam stage_t STAGE_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, rn: REG_ZERO};

endpackage

// File: rtl/pipe_hazard_unit_hazard_match.sv
// Single source-register versus pipeline-stage dependency comparator.
// A match needs a used, nonzero source and a writing stage with the same rn.
module hazard_match
    import pipe_hazard_unit_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic       src_used,
    input  stage_t     stage,
    output logic       match
);

    // The load flag is resolved by the caller; only the write target matters here.
    logic unused_m2reg;
    assign unused_m2reg = stage.m2reg;

    // Pure comparison, no state.
    assign match = src_used && (src_reg != REG_ZERO) && stage.wreg && (stage.rn == src_reg);

endmodule

// File: rtl/pipe_hazard_unit.sv
// ID-stage hazard controller for the five-stage MIPS pipeline.
// Tracks EX/MEM destination registers, drives the operand-mux selects and
// raises a stall on dependencies that cannot be forwarded.
// Build option: HAZARD_FORWARD_EN enables forwarding; without it the selects
// stay at the register file and any EX/MEM dependency stalls.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_wreg,
    input  logic                   id_m2reg,
    input  logic [4:0]             id_rn,
    input  logic                   flush,
    output logic [1:0]             fwda,
    output logic [1:0]             fwdb,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_ex_match, rs_mem_match, rt_ex_match, rt_mem_match;
    logic hazard;

    hazard_match u_rs_ex  (.src_reg(id_rs), .src_used(id_use_rs), .stage(ex_q),  .match(rs_ex_match));
    hazard_match u_rs_mem (.src_reg(id_rs), .src_used(id_use_rs), .stage(mem_q), .match(rs_mem_match));
    hazard_match u_rt_ex  (.src_reg(id_rt), .src_used(id_use_rt), .stage(ex_q),  .match(rt_ex_match));
    hazard_match u_rt_mem (.src_reg(id_rt), .src_used(id_use_rt), .stage(mem_q), .match(rt_mem_match));

`ifdef HAZARD_FORWARD_EN
    // Select per operand with EX priority; only a load still in EX must stall.
    always_comb begin
        fwda   = FWD_RF;
        fwdb   = FWD_RF;
        hazard = 1'b0;

        if (rs_ex_match && !ex_q.m2reg)        fwda = FWD_EXE;
        else if (rs_mem_match && !mem_q.m2reg) fwda = FWD_MEM;
        else if (rs_mem_match)                 fwda = FWD_MEM_LD;

        if (rt_ex_match && !ex_q.m2reg)        fwdb = FWD_EXE;
        else if (rt_mem_match && !mem_q.m2reg) fwdb = FWD_MEM;
        else if (rt_mem_match)                 fwdb = FWD_MEM_LD;

        hazard = (rs_ex_match || rt_ex_match) && ex_q.m2reg;
    end
`else
    // The load flag does not matter when nothing is forwarded.
    logic unused_mem_m2reg;
    assign unused_mem_m2reg = mem_q.m2reg;

    // No bypass paths: operands always come from the register file and any
    // in-flight producer of a source holds the ID instruction.
    always_comb begin
        fwda   = FWD_RF;
        fwdb   = FWD_RF;
        hazard = rs_ex_match || rs_mem_match || rt_ex_match || rt_mem_match;
    end
`endif

    // Stall gating, stage advance and saturating stall counter next-state.
    always_comb begin
        stall       = hazard && id_valid && !flush;
        mem_d       = ex_q;
        ex_d        = STAGE_BUBBLE;
        stall_cnt_d = stall_cnt_q;

        if (id_valid && !stall && !flush) begin
            ex_d.wreg  = id_wreg;
            ex_d.m2reg = id_m2reg;
            ex_d.rn    = id_rn;
        end

        if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stage and counter registers; reset overrides stall and flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q        <= STAGE_BUBBLE;
            mem_q       <= STAGE_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit. A behavioural model pushes the
// expected selects, stall and counters for each driven cycle into a queue;
// the entry is popped and compared against the DUT mid-cycle. A second DUT
// with a 4-bit counter shares the stimulus so saturation is reachable quickly.
// Expectations follow HAZARD_FORWARD_EN the same way the design does.
module tb_pipe_hazard_unit;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
    logic [4:0] id_rs, id_rt, id_rn;
    logic [1:0] fwda, fwdb, fwda4, fwdb4;
    logic       stall, stall4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    pipe_hazard_unit #(.STALL_CNT_W(16)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_rn(id_rn), .flush(flush),
        .fwda(fwda), .fwdb(fwdb), .stall(stall), .stall_cnt(stall_cnt)
    );

    pipe_hazard_unit #(.STALL_CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_rn(id_rn), .flush(flush),
        .fwda(fwda4), .fwdb(fwdb4), .stall(stall4), .stall_cnt(stall_cnt4)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_ex_w = 0, m_ex_m = 0, m_mem_w = 0, m_mem_m = 0;
    logic [4:0] m_ex_rn = 0, m_mem_rn = 0;
    logic [15:0] m_cnt = 0;
    logic [3:0]  m_cnt4 = 0;

    // {fwda, fwdb, stall, stall_cnt[15:0], stall_cnt4[3:0]}
    logic [24:0] exp_q[$];

    logic       obs_stall;
    logic [1:0] obs_fa, obs_fb;

    function automatic logic dep(input logic used, input logic [4:0] r,
                                 input logic w, input logic [4:0] rn);
        return used && (r != 5'd0) && w && (rn == r);
    endfunction

    function automatic logic [1:0] sel(input logic me, input logic mm);
        if (!FWD)                 return 2'b00;
        if (me && !m_ex_m)        return 2'b01;
        if (mm && !m_mem_m)       return 2'b10;
        if (mm)                   return 2'b11;
        return 2'b00;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic w,
                          input logic m, input logic [4:0] rn, input logic fl);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_wreg = w; id_m2reg = m; id_rn = rn; flush = fl;
    endtask

    task automatic set_nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // One clock with the current inputs: predict, compare mid-cycle, advance model.
    task automatic cycle();
        logic ae, am, be, bm, hz, st;
        logic [1:0] fa, fb;
        logic [24:0] e;
        ae = dep(id_use_rs, id_rs, m_ex_w, m_ex_rn);
        am = dep(id_use_rs, id_rs, m_mem_w, m_mem_rn);
        be = dep(id_use_rt, id_rt, m_ex_w, m_ex_rn);
        bm = dep(id_use_rt, id_rt, m_mem_w, m_mem_rn);
        fa = sel(ae, am);
        fb = sel(be, bm);
        hz = FWD ? ((ae || be) && m_ex_m) : (ae || am || be || bm);
        st = hz && id_valid && !flush;
        exp_q.push_back({fa, fb, st, m_cnt, m_cnt4});

        @(negedge clock);
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("fwda",       {30'd0, fwda},       {30'd0, e[24:23]});
            check_eq("fwdb",       {30'd0, fwdb},       {30'd0, e[22:21]});
            check_eq("stall",      {31'd0, stall},      {31'd0, e[20]});
            check_eq("stall_cnt",  {16'd0, stall_cnt},  {16'd0, e[19:4]});
            check_eq("fwda_w4",    {30'd0, fwda4},      {30'd0, e[24:23]});
            check_eq("stall_w4",   {31'd0, stall4},     {31'd0, e[20]});
            check_eq("stall_cnt4", {28'd0, stall_cnt4}, {28'd0, e[3:0]});
        end
        obs_stall = stall;
        obs_fa    = fwda;
        obs_fb    = fwdb;

        @(posedge clock);
        if (reset) begin
            m_ex_w = 0; m_ex_m = 0; m_ex_rn = 0;
            m_mem_w = 0; m_mem_m = 0; m_mem_rn = 0;
            m_cnt = 0; m_cnt4 = 0;
        end else begin
            m_mem_w = m_ex_w; m_mem_m = m_ex_m; m_mem_rn = m_ex_rn;
            if (id_valid && !st && !flush) begin
                m_ex_w = id_wreg; m_ex_m = id_m2reg; m_ex_rn = id_rn;
            end else begin
                m_ex_w = 0; m_ex_m = 0; m_ex_rn = 0;
            end
            if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (st && m_cnt4 != 4'hF)    m_cnt4 = m_cnt4 + 4'd1;
        end
        #1;
    endtask

    // Present an instruction and hold it in ID while the DUT stalls (bounded).
    task automatic run_insn(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                            input logic urt, input logic w, input logic m,
                            input logic [4:0] rn, output int stalls);
        set_id(1'b1, rs, urs, rt, urt, w, m, rn, 1'b0);
        stalls = 0;
        cycle();
        while (obs_stall && stalls < 8) begin
            stalls++;
            cycle();
        end
        set_nop();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1'b1;
        set_nop();
        @(posedge clock);
        #1;

        // Reset with a dependent-looking ID instruction present: nothing matches.
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
        repeat (2) cycle();
        check_eq("rst_stall", {31'd0, obs_stall}, 32'd0);
        check_eq("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        reset = 1'b0;
        set_nop();
        cycle();

        // add $3, then read rs=$3, then read rt=$3.
        run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, n);
        run_insn(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, n);
        check_eq("add_rs_stalls", n, FWD ? 0 : 2);
        check_eq("add_rs_fwda", {30'd0, obs_fa}, FWD ? 32'd1 : 32'd0);
        set_id(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        check_eq("add_rt_fwdb", {30'd0, obs_fb}, (FWD ? 32'd2 : 32'd0));
        set_nop();
        repeat (2) cycle();

        // lw $5, then dependent rs=$5.
        run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, n);
        run_insn(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, n);
        check_eq("lw_stalls", n, FWD ? 1 : 2);
        check_eq("lw_fwda", {30'd0, obs_fa}, FWD ? 32'd3 : 32'd0);
        repeat (2) cycle();

        // Two producers of $7: EX wins.
        run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, n);
        run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, n);
        run_insn(5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, n);
        check_eq("prio_stalls", n, FWD ? 0 : 2);
        repeat (2) cycle();
        run_insn(5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, n);
        run_insn(5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7, n);
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        check_eq("prio_fwda", {30'd0, obs_fa}, FWD ? 32'd1 : 32'd0);
        set_nop();
        repeat (2) cycle();

        // Producer of $0 never matches.
        run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, n);
        run_insn(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, n);
        check_eq("r0_stalls", n, 0);
        check_eq("r0_fwda", {30'd0, obs_fa}, 32'd0);

        // Load-use with flush: no stall, the squashed writer of $10 never lands.
        run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, n);
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd10, 1'b1);
        cycle();
        check_eq("flush_stall", {31'd0, obs_stall}, 32'd0);
        run_insn(5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0, n);
        check_eq("flush_stalls", n, 0);
        check_eq("flush_fwdb", {30'd0, obs_fb}, 32'd0);
        repeat (2) cycle();

        // Repeated load-use pairs drive the 4-bit counter into saturation.
        for (int i = 0; i < 16; i++) begin
            run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'(i % 30 + 1), n);
            run_insn(5'd0, 1'b0, 5'(i % 30 + 1), 1'b1, 1'b0, 1'b0, 5'd0, n);
        end
        check_eq("sat_cnt4", {28'd0, stall_cnt4}, 32'hF);

        // Reset in the middle of a stall clears the bubble state and counters.
        run_insn(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, n);
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        cycle();
        check_eq("pre_rst_stall", {31'd0, obs_stall}, 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check_eq("post_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        check_eq("post_rst_fwda", {30'd0, obs_fa}, 32'd0);
        set_nop();
        cycle();

        // Random traffic over a small register range to stress matches.
        for (int i = 0; i < 300; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 7) == 0));
            reset = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;
        set_nop();
        cycle();

        check_eq("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
